// File: rtl/updown_counter_n.sv
// Up/down modulo-N counter with synchronous load, optional saturation at the
// range ends, registered carry/borrow event pulses and combinational
// zero / at_max status flags.
module updown_counter_n #(
  parameter int     WIDTH    = 4,   // counter and data width (2..32)
  parameter longint MODULUS  = 16,  // count range is 0..MODULUS-1 (2..2^WIDTH)
  parameter int     SATURATE = 0    // 0: wrap at the ends, 1: hold at the ends
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             carry,
  output logic             borrow,
  output logic             zero,
  output logic             at_max
);

  // Top of the count range. MODULUS may equal 2^WIDTH, so the subtraction is
  // done at 64 bits before narrowing; the result always fits in WIDTH bits.
  localparam longint           MAX_L   = MODULUS - 1;
  localparam logic [WIDTH-1:0] MAX_VAL = MAX_L[WIDTH-1:0];
  localparam logic             SAT_EN  = (SATURATE != 0);

  logic [WIDTH-1:0] q_q, q_d;
  logic             carry_q, carry_d;
  logic             borrow_q, borrow_d;

  logic             q_is_max;
  logic             q_is_zero;

  assign q_is_max  = (q_q == MAX_VAL);
  assign q_is_zero = (q_q == '0);

  // Next-state logic: load beats count; carry/borrow only on the edge that
  // hits an end, so they self-clear into single-cycle pulses.
  always_comb begin
    q_d      = q_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    if (load) begin
      // Out-of-range load data clamps to the top so q never leaves 0..MODULUS-1.
      q_d = (d > MAX_VAL) ? MAX_VAL : d;
    end else if (en) begin
      if (up) begin
        if (q_is_max) begin
          carry_d = 1'b1;
          q_d     = SAT_EN ? MAX_VAL : '0;
        end else begin
          q_d = q_q + 1'b1;
        end
      end else begin
        if (q_is_zero) begin
          borrow_d = 1'b1;
          q_d      = SAT_EN ? '0 : MAX_VAL;
        end else begin
          q_d = q_q - 1'b1;
        end
      end
    end
  end

  // State register with synchronous reset that overrides load and count.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q      <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      q_q      <= q_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
    end
  end

  assign q      = q_q;
  assign carry  = carry_q;
  assign borrow = borrow_q;
  assign zero   = q_is_zero;
  assign at_max = q_is_max;

endmodule

// File: tb/tb_updown_counter_n.sv
// Self-checking bench for updown_counter_n: five differently parameterised
// instances share one stimulus stream; an arithmetic model tracks each one and
// is compared every cycle, plus directed sequences with literal expectations.
module tb_updown_counter_n;

  localparam int     NI = 5;
  localparam int     W_T [NI] = '{4, 4, 4, 8, 8};
  localparam longint M_T [NI] = '{16, 10, 10, 200, 256};
  localparam int     S_T [NI] = '{0, 0, 1, 1, 0};

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       up = 1'b0;
  logic       load = 1'b0;
  logic [7:0] d = 8'd0;

  logic [7:0] dq [NI];
  logic       dc [NI];
  logic       db [NI];
  logic       dz [NI];
  logic       da [NI];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      localparam int W = W_T[gi];
      logic [W-1:0] q_w;
      logic         c_w, b_w, z_w, a_w;
      updown_counter_n #(
        .WIDTH   (W),
        .MODULUS (M_T[gi]),
        .SATURATE(S_T[gi])
      ) u_dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .up    (up),
        .load  (load),
        .d     (d[W-1:0]),
        .q     (q_w),
        .carry (c_w),
        .borrow(b_w),
        .zero  (z_w),
        .at_max(a_w)
      );
      assign dq[gi] = 8'(q_w);
      assign dc[gi] = c_w;
      assign db[gi] = b_w;
      assign dz[gi] = z_w;
      assign da[gi] = a_w;
    end
  endgenerate

  // ---------------- reference model ----------------
  longint mq [NI];
  bit     mc [NI];
  bit     mb [NI];
  bit     model_valid = 1'b0;

  initial begin
    for (int i = 0; i < NI; i++) begin
      mq[i] = 0;
      mc[i] = 1'b0;
      mb[i] = 1'b0;
    end
  end

  function automatic longint mdl_q(int i);
    longint m  = M_T[i];
    longint dv = longint'(d) & ((64'd1 << W_T[i]) - 1);
    if (rst)  return 0;
    if (load) return (dv < m) ? dv : m - 1;
    if (!en)  return mq[i];
    if (up) begin
      if (S_T[i] != 0 && mq[i] == m - 1) return mq[i];
      return (mq[i] + 1) % m;
    end
    if (mq[i] == 0) return (S_T[i] != 0) ? 0 : m - 1;
    return mq[i] - 1;
  endfunction

  function automatic bit mdl_c(int i);
    return !rst && !load && en && up && (mq[i] == M_T[i] - 1);
  endfunction

  function automatic bit mdl_b(int i);
    return !rst && !load && en && !up && (mq[i] == 0);
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      mq[i] <= mdl_q(i);
      mc[i] <= mdl_c(i);
      mb[i] <= mdl_b(i);
    end
    if (rst) model_valid <= 1'b1;
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every instance against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (model_valid) begin
        for (int i = 0; i < NI; i++) begin
          chk($sformatf("model_q[%0d]", i), 64'(dq[i]), 64'(mq[i]));
          chk($sformatf("model_carry[%0d]", i), 64'(dc[i]), 64'(mc[i]));
          chk($sformatf("model_borrow[%0d]", i), 64'(db[i]), 64'(mb[i]));
          chk($sformatf("model_zero[%0d]", i), 64'(dz[i]), 64'(mq[i] == 0));
          chk($sformatf("model_at_max[%0d]", i), 64'(da[i]), 64'(mq[i] == M_T[i] - 1));
          chk($sformatf("excl_carry_borrow[%0d]", i), 64'(dc[i] & db[i]), 64'd0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic r, input logic l, input logic e,
                        input logic u, input logic [7:0] dv);
    rst = r; load = l; en = e; up = u; d = dv;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset state
    set_in(1, 0, 0, 0, 0);
    tick();
    chk("reset_q", 64'(dq[0]), 64'd0);
    chk("reset_carry", 64'(dc[0]), 64'd0);
    chk("reset_zero", 64'(dz[0]), 64'd1);
    chk("reset_at_max", 64'(da[0]), 64'd0);

    // Wrap-up, MODULUS=16: q runs 1..15 then 0, carry only on 15->0
    set_in(0, 0, 1, 1, 0);
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk($sformatf("wrapup_q%0d", i), 64'(dq[0]), 64'(i % 16));
      chk($sformatf("wrapup_carry%0d", i), 64'(dc[0]), 64'(i == 16));
    end

    // Wrap-down, MODULUS=10
    set_in(1, 0, 0, 0, 0);
    tick();
    set_in(0, 0, 1, 0, 0);
    tick();
    chk("wrapdn_q", 64'(dq[1]), 64'd9);
    chk("wrapdn_borrow", 64'(db[1]), 64'd1);
    chk("wrapdn_at_max", 64'(da[1]), 64'd1);
    tick();
    chk("wrapdn_q2", 64'(dq[1]), 64'd8);
    chk("wrapdn_borrow2", 64'(db[1]), 64'd0);

    // Saturate, MODULUS=10: load 8 then three up edges -> 9,9,9 / carry 0,1,1
    set_in(0, 1, 0, 0, 8'd8);
    tick();
    set_in(0, 0, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("sat_q%0d", i), 64'(dq[2]), 64'd9);
      chk($sformatf("sat_carry%0d", i), 64'(dc[2]), 64'(i != 0));
    end
    // Saturate at bottom: load 0, down twice -> hold 0 with borrow each edge
    set_in(0, 1, 0, 0, 8'd0);
    tick();
    set_in(0, 0, 1, 0, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk($sformatf("satdn_q%0d", i), 64'(dq[2]), 64'd0);
      chk($sformatf("satdn_borrow%0d", i), 64'(db[2]), 64'd1);
    end

    // Load clamp and priority
    set_in(0, 1, 1, 1, 8'd12);
    tick();
    chk("clamp_q_m10", 64'(dq[1]), 64'd9);
    chk("clamp_carry_m10", 64'(dc[1]), 64'd0);
    chk("clamp_q_m16", 64'(dq[0]), 64'd12);
    set_in(1, 1, 1, 1, 8'd5);
    tick();
    chk("rst_over_load_q", 64'(dq[1]), 64'd0);
    chk("rst_over_load_zero", 64'(dz[1]), 64'd1);

    // Mid-count reset: reach q=7 counting up, reset with en=1, then count
    set_in(0, 1, 0, 0, 8'd6);
    tick();
    set_in(0, 0, 1, 1, 0);
    tick();
    chk("mid_pre_q", 64'(dq[0]), 64'd7);
    set_in(1, 0, 1, 1, 0);
    tick();
    chk("mid_rst_q", 64'(dq[0]), 64'd0);
    chk("mid_rst_carry", 64'(dc[0]), 64'd0);
    chk("mid_rst_zero", 64'(dz[0]), 64'd1);
    set_in(0, 0, 1, 1, 0);
    tick();
    chk("mid_after_q", 64'(dq[0]), 64'd1);

    // Direction change takes effect on the next enabled edge
    set_in(0, 0, 1, 0, 0);
    tick();
    chk("dirchg_q", 64'(dq[0]), 64'd0);

    // Randomised run checked by the model every cycle
    for (int n = 0; n < 10000; n++) begin
      set_in($urandom_range(0, 49) == 0,
             $urandom_range(0, 7) == 0,
             $urandom_range(0, 3) != 0,
             1'($urandom_range(0, 1)),
             8'($urandom));
      tick();
    end

    set_in(0, 0, 0, 0, 0);
    tick();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
